// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared constants, scoreboard types and helpers for hazard_ctrl
package hazard_pkg;

    localparam logic [1:0] FWD_D_GRF = 2'b00;
    localparam logic [1:0] FWD_D_E   = 2'b01;
    localparam logic [1:0] FWD_D_M   = 2'b10;
    localparam logic [1:0] FWD_D_W   = 2'b11;

    localparam logic [1:0] FWD_E_REG = 2'b00;
    localparam logic [1:0] FWD_E_M   = 2'b01;
    localparam logic [1:0] FWD_E_W   = 2'b10;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam logic [1:0] TNEW_JAL  = 2'd0;
    localparam logic [1:0] TNEW_ALU  = 2'd1;
    localparam logic [1:0] TNEW_LOAD = 2'd2;

    // E-stage entry: destination, result-ready time and the sources it reads
    typedef struct packed {
        logic [4:0] wa;
        logic [1:0] tnew;
        logic [4:0] rs;
        logic [4:0] rt;
    } sb_entry_t;

    // M/W entries only need the destination side
    typedef struct packed {
        logic [4:0] wa;
        logic [1:0] tnew;
    } sb_dst_t;

    function automatic logic [1:0] decTnew(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

endpackage

// File: rtl/hazard_if.sv
// rtl/hazard_if.sv - D-stage request and hazard control bundle (md_* present with HAZARD_MDU_EN)
interface hazard_if;
    logic [4:0] rs_d;
    logic [4:0] rt_d;
    logic [1:0] tuse_rs_d;
    logic [1:0] tuse_rt_d;
    logic [4:0] wa_d;
    logic [1:0] tnew_d;
`ifdef HAZARD_MDU_EN
    logic       md_start_e;
    logic       md_div_e;
    logic       md_use_d;
`endif
    logic       stall;
    logic [1:0] fwd_rs_d;
    logic [1:0] fwd_rt_d;
    logic [1:0] fwd_rs_e;
    logic [1:0] fwd_rt_e;

    modport master (
`ifdef HAZARD_MDU_EN
        output md_start_e, md_div_e, md_use_d,
`endif
        output rs_d, rt_d, tuse_rs_d, tuse_rt_d, wa_d, tnew_d,
        input  stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e
    );

    modport slave (
`ifdef HAZARD_MDU_EN
        input  md_start_e, md_div_e, md_use_d,
`endif
        input  rs_d, rt_d, tuse_rs_d, tuse_rt_d, wa_d, tnew_d,
        output stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e
    );
endinterface

// File: rtl/hazard_md_busy.sv
// rtl/hazard_md_busy.sv - multiply/divide unit busy counter
module hazard_md_busy #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic md_start_e,
    input  logic md_div_e,
    output logic busy
);
    localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    logic [CNT_W-1:0] cnt;

    // Load the operation latency on start, otherwise count down to idle
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (md_start_e) begin
            cnt <= md_div_e ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign busy = md_start_e | (cnt != '0);
endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/forward controller for the five-stage pipeline (option: HAZARD_MDU_EN)
module hazard_ctrl
`ifdef HAZARD_MDU_EN
#(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
)
`endif
(
    input  logic     clk,
    input  logic     reset,
    hazard_if.slave  bus
);
    import hazard_pkg::*;

    sb_entry_t eEnt;
    sb_dst_t   mEnt;
    sb_dst_t   wEnt;
    logic      rsStall;
    logic      rtStall;
    logic      mdStall;

    // A source stalls while a producer in E or M will not have its result in time
    function automatic logic srcHazard(input logic [4:0] r, input logic [1:0] u,
                                       input logic [4:0] eWa, input logic [1:0] eTnew,
                                       input logic [4:0] mWa, input logic [1:0] mTnew);
        return (r != 5'd0) && (u != TUSE_NONE) &&
               (((r == eWa) && (eTnew > u)) || ((r == mWa) && (mTnew > u)));
    endfunction

    // Nearest producer whose result already exists wins
    function automatic logic [1:0] selD(input logic [4:0] r,
                                        input logic [4:0] eWa, input logic [1:0] eTnew,
                                        input logic [4:0] mWa, input logic [1:0] mTnew,
                                        input logic [4:0] wWa, input logic [1:0] wTnew);
        if (r == 5'd0)                             return FWD_D_GRF;
        if ((r == eWa) && (eTnew == TNEW_JAL))     return FWD_D_E;
        if ((r == mWa) && (mTnew == TNEW_JAL))     return FWD_D_M;
        if ((r == wWa) && (wTnew == TNEW_JAL))     return FWD_D_W;
        return FWD_D_GRF;
    endfunction

    // W results are always complete, so only M needs the readiness check
    function automatic logic [1:0] selE(input logic [4:0] r,
                                        input logic [4:0] mWa, input logic [1:0] mTnew,
                                        input logic [4:0] wWa);
        if (r == 5'd0)                             return FWD_E_REG;
        if ((r == mWa) && (mTnew == TNEW_JAL))     return FWD_E_M;
        if (r == wWa)                              return FWD_E_W;
        return FWD_E_REG;
    endfunction

`ifdef HAZARD_MDU_EN
    logic mdBusy;

    hazard_md_busy #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) u_md_busy (
        .clk        (clk),
        .reset      (reset),
        .md_start_e (bus.md_start_e),
        .md_div_e   (bus.md_div_e),
        .busy       (mdBusy)
    );

    assign mdStall = bus.md_use_d & mdBusy;
`else
    assign mdStall = 1'b0;
`endif

    // Scoreboard shifts with the pipeline registers; a stall injects a bubble into E
    always_ff @(posedge clk) begin
        if (reset) begin
            eEnt <= '0;
            mEnt <= '0;
            wEnt <= '0;
        end else begin
            if (bus.stall) begin
                eEnt <= '0;
            end else begin
                eEnt.wa   <= bus.wa_d;
                eEnt.tnew <= bus.tnew_d;
                eEnt.rs   <= bus.rs_d;
                eEnt.rt   <= bus.rt_d;
            end
            mEnt.wa   <= eEnt.wa;
            mEnt.tnew <= decTnew(eEnt.tnew);
            wEnt.wa   <= mEnt.wa;
            wEnt.tnew <= decTnew(mEnt.tnew);
        end
    end

    // Combinational stall and forwarding selects from current state and D inputs
    always_comb begin
        rsStall      = srcHazard(bus.rs_d, bus.tuse_rs_d, eEnt.wa, eEnt.tnew, mEnt.wa, mEnt.tnew);
        rtStall      = srcHazard(bus.rt_d, bus.tuse_rt_d, eEnt.wa, eEnt.tnew, mEnt.wa, mEnt.tnew);
        bus.stall    = rsStall | rtStall | mdStall;
        bus.fwd_rs_d = selD(bus.rs_d, eEnt.wa, eEnt.tnew, mEnt.wa, mEnt.tnew, wEnt.wa, wEnt.tnew);
        bus.fwd_rt_d = selD(bus.rt_d, eEnt.wa, eEnt.tnew, mEnt.wa, mEnt.tnew, wEnt.wa, wEnt.tnew);
        bus.fwd_rs_e = selE(eEnt.rs, mEnt.wa, mEnt.tnew, wEnt.wa);
        bus.fwd_rt_e = selE(eEnt.rt, mEnt.wa, mEnt.tnew, wEnt.wa);
    end
endmodule
